// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI responder peripheral.
package spi_slave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_PUSH  = 2'd3
  } spi_slv_state_e;

  localparam int STAT_RX_NOT_EMPTY = 0;
  localparam int STAT_RX_FULL      = 1;
  localparam int STAT_TX_PENDING   = 2;
  localparam int STAT_BUSY         = 3;
  localparam int STAT_OVERRUN      = 4;
  localparam int STAT_UNDERRUN     = 5;
  localparam int STAT_IRQ_EN       = 8;
  localparam int STAT_COUNT_LSB    = 16;
  localparam int STAT_COUNT_W      = 5;

  localparam logic REG_CTRL = 1'b0;
  localparam logic REG_DATA = 1'b1;

endpackage

// File: rtl/spi_slave_port_if.sv
// Processor-side register bus of the SPI responder.
interface spi_slave_port_if;
  logic        wr_pi;
  logic        rd_pi;
  logic        reg_sel_pi;
  logic [31:0] entrada_pi;
  logic [31:0] salida_po;

  modport master (output wr_pi, rd_pi, reg_sel_pi, entrada_pi, input salida_po);
  modport slave  (input wr_pi, rd_pi, reg_sel_pi, entrada_pi, output salida_po);
endinterface

// File: rtl/spi_slave_rx_fifo.sv
// Receive byte FIFO; pushes into a full FIFO and pops from an empty one are dropped.
module spi_slave_rx_fifo #(
  parameter int RX_DEPTH = 4
) (
  input  logic                      clk_pi,
  input  logic                      reset_pi,
  input  logic                      push,
  input  logic                      pop,
  input  logic [7:0]                din,
  output logic [7:0]                dout,
  output logic                      empty,
  output logic                      full,
  output logic [$clog2(RX_DEPTH):0] count
);
  localparam int AW = $clog2(RX_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(RX_DEPTH);

  logic [7:0]    mem [RX_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == FULL_CNT);
  assign count   = cnt;
  assign dout    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk_pi) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk_pi) begin
    if (reset_pi) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/spi_slave_port.sv
// Mode-0 SPI responder: TX holding register out on MISO, received bytes into an RX FIFO.
//   state | meaning
//   IDLE  | no frame, miso low, wait for cs fall
//   LOAD  | fetch tx_hold (or 0x00 on underrun) into tx_shift
//   SHIFT | sample mosi on rise, advance tx_shift on fall
//   PUSH  | store completed byte, arm reload for next fall
module spi_slave_port
  import spi_slave_pkg::*;
#(
  parameter int RX_DEPTH    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_pi,
  input  logic              reset_pi,
  spi_slave_port_if.slave   bus,
  input  logic              sclk_pi,
  input  logic              cs_pi,
  input  logic              mosi_pi,
  output logic              miso_po,
  output logic              irq_po
);
  localparam int CW = $clog2(RX_DEPTH) + 1;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_s, cs_s, mosi_s, sclk_d, cs_d;
  logic                   rise, fall, cs_fall, cs_rise;

  spi_slv_state_e state, state_n;
  logic [3:0]     bit_cnt, bit_cnt_n;
  logic [7:0]     tx_shift, tx_shift_n, rx_shift, rx_shift_n, tx_hold;
  logic           tx_pending, tx_pending_n, reload, reload_n;
  logic           overrun, underrun, irq_en, ovr_set, und_set, load_evt, miso_n;

  logic           fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [7:0]     fifo_dout;
  logic [CW-1:0]  fifo_count;
  logic           data_wr, ctrl_wr;
  logic [31:0]    status;
  logic           unused_entrada;

  assign sclk_s  = sclk_sync[SYNC_STAGES-1];
  assign cs_s    = cs_sync[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync[SYNC_STAGES-1];
  assign rise    = sclk_s & ~sclk_d;
  assign fall    = ~sclk_s & sclk_d;
  assign cs_fall = ~cs_s & cs_d;
  assign cs_rise = cs_s & ~cs_d;

  // cs chain clears to low so a frame already in progress at reset release gives no fall edge.
  always_ff @(posedge clk_pi) begin
    if (reset_pi) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_pi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_pi};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_pi};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  assign data_wr  = bus.wr_pi & (bus.reg_sel_pi == REG_DATA);
  assign ctrl_wr  = bus.wr_pi & (bus.reg_sel_pi == REG_CTRL);
  assign fifo_pop = bus.rd_pi & (bus.reg_sel_pi == REG_DATA);

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    tx_shift_n = tx_shift;
    rx_shift_n = rx_shift;
    reload_n   = reload;
    load_evt   = 1'b0;
    fifo_push  = 1'b0;
    ovr_set    = 1'b0;
    if (cs_rise) begin
      state_n  = ST_IDLE;
      reload_n = 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (cs_fall) state_n = ST_LOAD;
        ST_LOAD: begin
          load_evt  = 1'b1;
          bit_cnt_n = 4'd0;
          reload_n  = 1'b0;
          state_n   = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (rise) begin
            rx_shift_n = {rx_shift[6:0], mosi_s};
            bit_cnt_n  = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) state_n = ST_PUSH;
          end
          if (fall) begin
            if (reload) begin
              load_evt = 1'b1;
              reload_n = 1'b0;
            end else begin
              tx_shift_n = {tx_shift[6:0], 1'b0};
            end
          end
        end
        ST_PUSH: begin
          fifo_push = ~fifo_full;
          ovr_set   = fifo_full;
          bit_cnt_n = 4'd0;
          reload_n  = 1'b1;
          state_n   = ST_SHIFT;
        end
        default: state_n = ST_IDLE;
      endcase
    end
    if (load_evt) tx_shift_n = tx_pending ? tx_hold : 8'h00;
    und_set      = load_evt & ~tx_pending;
    // a same-cycle bus write lands after the load has consumed the old byte
    tx_pending_n = (tx_pending & ~load_evt) | data_wr;
    miso_n       = ((state_n == ST_SHIFT) || (state_n == ST_PUSH)) & tx_shift_n[7];
  end

  always_ff @(posedge clk_pi) begin
    if (reset_pi) begin
      state      <= ST_IDLE;
      bit_cnt    <= 4'd0;
      tx_shift   <= 8'h00;
      rx_shift   <= 8'h00;
      tx_hold    <= 8'h00;
      tx_pending <= 1'b0;
      reload     <= 1'b0;
      overrun    <= 1'b0;
      underrun   <= 1'b0;
      irq_en     <= 1'b0;
      miso_po    <= 1'b0;
      irq_po     <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      tx_shift   <= tx_shift_n;
      rx_shift   <= rx_shift_n;
      tx_pending <= tx_pending_n;
      reload     <= reload_n;
      miso_po    <= miso_n;
      if (data_wr) tx_hold <= bus.entrada_pi[7:0];
      if (ctrl_wr) irq_en  <= bus.entrada_pi[STAT_IRQ_EN];
      overrun  <= ovr_set | (overrun  & ~(ctrl_wr & bus.entrada_pi[STAT_OVERRUN]));
      underrun <= und_set | (underrun & ~(ctrl_wr & bus.entrada_pi[STAT_UNDERRUN]));
      irq_po   <= irq_en & (~fifo_empty | overrun);
    end
  end

  spi_slave_rx_fifo #(.RX_DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_pi   (clk_pi),
    .reset_pi (reset_pi),
    .push     (fifo_push),
    .pop      (fifo_pop),
    .din      (rx_shift),
    .dout     (fifo_dout),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .count    (fifo_count)
  );

  always_comb begin
    status                                     = '0;
    status[STAT_RX_NOT_EMPTY]                  = ~fifo_empty;
    status[STAT_RX_FULL]                       = fifo_full;
    status[STAT_TX_PENDING]                    = tx_pending;
    status[STAT_BUSY]                          = (state != ST_IDLE);
    status[STAT_OVERRUN]                       = overrun;
    status[STAT_UNDERRUN]                      = underrun;
    status[STAT_IRQ_EN]                        = irq_en;
    status[STAT_COUNT_LSB +: STAT_COUNT_W]     = STAT_COUNT_W'(fifo_count);
  end

  assign bus.salida_po = (bus.reg_sel_pi == REG_DATA) ?
                         (fifo_empty ? 32'h0 : {24'h0, fifo_dout}) : status;

  assign unused_entrada = ^bus.entrada_pi[31:9];
endmodule

// File: tb/tb_spi_slave_port.sv
// Scoreboard bench for spi_slave_port: bus reads and MISO bytes checked by independent monitors.
module tb_spi_slave_port;
  localparam int RX_DEPTH = 4;
  localparam int SYNC     = 2;
  localparam int H        = 6;

  logic clk = 1'b0, reset = 1'b1, sclk = 1'b0, cs = 1'b1, mosi = 1'b0;
  logic miso, irq;

  spi_slave_port_if bus ();

  spi_slave_port #(.RX_DEPTH(RX_DEPTH), .SYNC_STAGES(SYNC)) dut (
    .clk_pi   (clk),
    .reset_pi (reset),
    .bus      (bus),
    .sclk_pi  (sclk),
    .cs_pi    (cs),
    .mosi_pi  (mosi),
    .miso_po  (miso),
    .irq_po   (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;

  // reference model state
  logic [7:0]  m_fifo[$];
  logic [7:0]  m_hold = 8'h00;
  bit          m_pending = 0, m_ovr = 0, m_und = 0, m_irq_en = 0, m_busy = 0;
  logic [7:0]  exp_miso[$];
  logic [31:0] exp_bus[$];
  logic [7:0]  frame_q[$];
  bit          mon_en = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    int          n;
    n     = m_fifo.size();
    s     = '0;
    s[0]  = (n != 0);
    s[1]  = (n == RX_DEPTH);
    s[2]  = m_pending;
    s[3]  = m_busy;
    s[4]  = m_ovr;
    s[5]  = m_und;
    s[8]  = m_irq_en;
    s[20:16] = n[4:0];
    return s;
  endfunction

  function automatic logic m_irq();
    return m_irq_en & ((m_fifo.size() != 0) | m_ovr);
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input bit sel);
    logic [31:0] e;
    if (sel) begin
      if (m_fifo.size() != 0) e = {24'h0, m_fifo.pop_front()};
      else e = 32'h0;
    end else begin
      e = m_status();
    end
    exp_bus.push_back(e);
    bus.rd_pi = 1'b1;
    bus.reg_sel_pi = sel;
    wait_cyc(1);
    bus.rd_pi = 1'b0;
  endtask

  task automatic bus_write(input bit sel, input logic [31:0] d);
    bus.wr_pi = 1'b1;
    bus.reg_sel_pi = sel;
    bus.entrada_pi = d;
    wait_cyc(1);
    bus.wr_pi = 1'b0;
    if (sel) begin
      m_hold = d[7:0];
      m_pending = 1;
    end else begin
      m_irq_en = d[8];
      if (d[4]) m_ovr = 0;
      if (d[5]) m_und = 0;
    end
  endtask

  task automatic model_load(input bit counted);
    logic [7:0] b;
    if (m_pending) begin
      b = m_hold;
      m_pending = 0;
    end else begin
      b = 8'h00;
      m_und = 1;
    end
    if (counted) exp_miso.push_back(b);
  endtask

  task automatic model_rx(input logic [7:0] b);
    if (m_fifo.size() < RX_DEPTH) m_fifo.push_back(b);
    else m_ovr = 1;
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_hold = 8'h00;
    m_pending = 0;
    m_ovr = 0;
    m_und = 0;
    m_irq_en = 0;
    m_busy = 0;
  endtask

  // mid_op: 0 none, 1 TX write, 2 status read, after bit 3 of byte 0
  task automatic spi_frame(input int nbits, input int mid_op, input logic [7:0] mid_val,
                           input int pop_byte);
    int nfull, k, b;
    nfull = nbits / 8;
    m_busy = 1;
    cs = 1'b0;
    model_load(nfull > 0);
    wait_cyc(8);
    for (int i = 0; i < nbits; i++) begin
      k = i / 8;
      b = i % 8;
      mosi = frame_q[k][7-b];
      wait_cyc(H);
      sclk = 1'b1;
      if (b == 7 && k == pop_byte) begin
        wait_cyc(SYNC + 1);
        bus_read(1);
        wait_cyc(H - SYNC - 2);
      end else begin
        wait_cyc(H);
      end
      sclk = 1'b0;
      if (b == 7) begin
        model_rx(frame_q[k]);
        model_load(k + 1 < nfull);
      end
      if (b == 3 && k == 0 && mid_op == 1) bus_write(1, {24'h0, mid_val});
      if (b == 3 && k == 0 && mid_op == 2) bus_read(0);
    end
    wait_cyc(H);
    cs = 1'b1;
    m_busy = 0;
    wait_cyc(8);
  endtask

  // MISO monitor: assembles the byte the master samples on each sclk rise
  logic [7:0] mon_bits = 8'h00;
  int         mon_n = 0;
  always @(posedge sclk or posedge cs) begin
    if (cs) begin
      mon_n = 0;
    end else if (mon_en) begin
      mon_bits = {mon_bits[6:0], miso};
      mon_n++;
      if (mon_n == 8) begin
        mon_n = 0;
        if (exp_miso.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL miso_unexpected: got %h expected none", mon_bits);
        end else begin
          check("miso_byte", {24'h0, mon_bits}, {24'h0, exp_miso.pop_front()});
        end
      end
    end
  end

  always @(negedge clk) begin
    if (bus.rd_pi === 1'b1) begin
      if (exp_bus.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL bus_unexpected: got %h expected none", bus.salida_po);
      end else begin
        check("bus_read", bus.salida_po, exp_bus.pop_front());
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    int         n, nbits;

    bus.wr_pi = 1'b0;
    bus.rd_pi = 1'b0;
    bus.reg_sel_pi = 1'b0;
    bus.entrada_pi = 32'h0;
    wait_cyc(4);
    reset = 1'b0;
    wait_cyc(2);
    check("reset_miso", {31'h0, miso}, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);
    bus_read(0);
    bus_read(1);

    // single byte
    bus_write(1, 32'h0000_00A5);
    bus_read(0);
    frame_q = '{8'h3C};
    spi_frame(8, 0, 8'h00, -1);
    bus_read(0);
    bus_read(1);
    bus_read(0);
    bus_write(0, 32'h20);

    // underrun across a two-byte frame
    frame_q = '{8'h11, 8'h22};
    spi_frame(16, 0, 8'h00, -1);
    bus_read(0);
    bus_write(0, 32'h20);
    bus_read(0);
    bus_read(1);
    bus_read(1);

    // overrun with interrupts enabled
    bus_write(0, 32'h100);
    frame_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    spi_frame(40, 0, 8'h00, -1);
    wait_cyc(2);
    check("irq_overrun", {31'h0, irq}, {31'h0, m_irq()});
    bus_read(0);
    repeat (4) bus_read(1);
    bus_read(1);
    bus_write(0, 32'h130);
    wait_cyc(2);
    check("irq_cleared", {31'h0, irq}, {31'h0, m_irq()});
    bus_read(0);

    // aborted frame
    frame_q = '{8'h77};
    spi_frame(8, 0, 8'h00, -1);
    frame_q = '{8'hFF};
    spi_frame(5, 0, 8'h00, -1);
    bus_read(0);
    bus_write(1, 32'h99);
    frame_q = '{8'h81};
    spi_frame(8, 0, 8'h00, -1);
    bus_read(0);
    bus_read(1);
    bus_read(1);

    // push coinciding with pop at count 2
    frame_q = '{8'hA1, 8'hB2};
    spi_frame(16, 0, 8'h00, -1);
    frame_q = '{8'hC3};
    spi_frame(8, 2, 8'h00, 0);
    bus_read(0);
    bus_read(1);
    bus_read(1);
    bus_read(0);

    // reset in the middle of a frame with cs held low
    bus_write(0, 32'h100);
    frame_q = '{8'h44};
    spi_frame(8, 0, 8'h00, -1);
    wait_cyc(2);
    check("irq_pre_reset", {31'h0, irq}, {31'h0, m_irq()});
    d = 8'hE7;
    mon_en = 0;
    cs = 1'b0;
    wait_cyc(8);
    for (int b = 0; b < 3; b++) begin
      mosi = d[7-b];
      wait_cyc(H);
      sclk = 1'b1;
      wait_cyc(H);
      sclk = 1'b0;
    end
    mosi = d[4];
    wait_cyc(H);
    sclk = 1'b1;
    wait_cyc(2);
    reset = 1'b1;
    wait_cyc(2);
    reset = 1'b0;
    model_reset();
    wait_cyc(1);
    check("midreset_miso", {31'h0, miso}, 32'h0);
    check("midreset_irq", {31'h0, irq}, 32'h0);
    bus_read(0);
    bus_read(1);
    sclk = 1'b0;
    for (int b = 4; b < 8; b++) begin
      mosi = d[7-b];
      wait_cyc(H);
      sclk = 1'b1;
      wait_cyc(H);
      check("ignored_miso", {31'h0, miso}, 32'h0);
      sclk = 1'b0;
    end
    wait_cyc(H);
    bus_read(0);
    cs = 1'b1;
    wait_cyc(8);
    mon_en = 1;
    frame_q = '{8'h5A};
    spi_frame(8, 0, 8'h00, -1);
    bus_read(0);
    bus_read(1);

    // randomized traffic
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 1) == 1) bus_write(1, $urandom);
      n = $urandom_range(1, 3);
      frame_q.delete();
      for (int j = 0; j < n; j++) frame_q.push_back(8'($urandom));
      nbits = ($urandom_range(0, 4) == 0) ? n * 8 - int'($urandom_range(1, 7)) : n * 8;
      spi_frame(nbits, int'($urandom_range(0, 2)), 8'($urandom), -1);
      repeat ($urandom_range(0, 3)) bus_read(1);
      if ($urandom_range(0, 3) == 0) bus_write(0, $urandom & 32'h130);
      bus_read(0);
      wait_cyc(2);
      check("irq_level", {31'h0, irq}, {31'h0, m_irq()});
    end

    wait_cyc(4);
    check("miso_queue_drained", exp_miso.size(), 32'h0);
    check("bus_queue_drained", exp_bus.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
